crypto_seq_unit: RTL and testbench

CRYPTO_SEQ_UNIT -- requirements
Module: crypto_seq_unit

---
 rtl/crypto_seq_unit.sv | 168 ++++++++++++++++
 tb/tb_crypto_seq_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/crypto_seq_unit.sv
// Control sequencer for an iterative AES-style datapath, plus a free-running
// two-lane S-box (forward / inverse) register.
module crypto_seq_unit #(
  parameter int unsigned ROUNDS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bgn,
  input  logic [1:0]  cript_or_decript,
  output logic [21:0] ctrl,
  output logic [2:0]  counter,
  input  logic [15:0] sbox_in,
  input  logic        sbox_fwd_en,
  input  logic        sbox_inv_en,
  output logic [15:0] sbox_out
);

  localparam logic [2:0] LAST_ROUND = 3'(ROUNDS);

  typedef enum logic [4:0] {
    IDLE, LOAD,
    E_XOR, E_SAVE, E_SUB, E_SHIFT, E_CNT, E_MIX, E_KEY, E_ADD,
    E_OUT, E_DOUT, E_KOUT,
    D_XOR, D_SHIFT, D_SUB, D_CNT, D_KLD, D_KSUB, D_ADD, D_IMIX, D_SAVE,
    D_LSUB, D_LXOR, D_DOUT, D_KOUT,
    DONE
  } state_t;

  state_t     state, nxt;
  logic [1:0] mode;

  function automatic logic [21:0] strobe(input state_t s);
    logic [21:0] r;
    r = '0;
    case (s)
      LOAD:    r[0]  = 1'b1;
      E_XOR:   r[1]  = 1'b1;
      E_SAVE:  r[2]  = 1'b1;
      E_SUB:   r[3]  = 1'b1;
      E_SHIFT: r[4]  = 1'b1;
      E_CNT:   r[5]  = 1'b1;
      D_CNT:   r[5]  = 1'b1;
      E_MIX:   r[6]  = 1'b1;
      E_KEY:   r[7]  = 1'b1;
      E_ADD:   r[8]  = 1'b1;
      D_XOR:   r[9]  = 1'b1;
      D_SAVE:  r[10] = 1'b1;
      D_SHIFT: r[11] = 1'b1;
      D_SUB:   r[12] = 1'b1;
      D_KLD:   r[13] = 1'b1;
      D_KSUB:  r[14] = 1'b1;
      D_ADD:   r[15] = 1'b1;
      D_IMIX:  r[16] = 1'b1;
      D_LSUB:  r[17] = 1'b1;
      D_LXOR:  r[18] = 1'b1;
      E_OUT:   r[19] = 1'b1;
      E_DOUT:  r[20] = 1'b1;
      D_DOUT:  r[20] = 1'b1;
      E_KOUT:  r[21] = 1'b1;
      D_KOUT:  r[21] = 1'b1;
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bgn && (cript_or_decript == 2'b01 || cript_or_decript == 2'b10)) nxt = LOAD;
      LOAD:    nxt = (mode == 2'b01) ? E_XOR : D_XOR;
      E_XOR:   nxt = E_SAVE;
      E_SAVE:  nxt = E_SUB;
      E_SUB:   nxt = E_SHIFT;
      E_SHIFT: nxt = E_CNT;
      E_CNT:   nxt = E_MIX;
      E_MIX:   nxt = E_KEY;
      E_KEY:   nxt = E_ADD;
      E_ADD:   nxt = (counter != LAST_ROUND) ? E_SAVE : E_OUT;
      E_OUT:   nxt = E_DOUT;
      E_DOUT:  nxt = E_KOUT;
      E_KOUT:  nxt = DONE;
      D_XOR:   nxt = D_SHIFT;
      D_SHIFT: nxt = D_SUB;
      D_SUB:   nxt = D_CNT;
      D_CNT:   nxt = D_KLD;
      D_KLD:   nxt = D_KSUB;
      D_KSUB:  nxt = D_ADD;
      D_ADD:   nxt = D_IMIX;
      D_IMIX:  nxt = D_SAVE;
      D_SAVE:  nxt = (counter != LAST_ROUND) ? D_SHIFT : D_LSUB;
      D_LSUB:  nxt = D_LXOR;
      D_LXOR:  nxt = D_DOUT;
      D_DOUT:  nxt = D_KOUT;
      D_KOUT:  nxt = DONE;
      DONE:    if (!bgn) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // ctrl is registered from the next state so it always matches the current state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      ctrl    <= '0;
      counter <= '0;
      mode    <= '0;
    end else begin
      state <= nxt;
      ctrl  <= strobe(nxt);
      if (state == IDLE && nxt == LOAD) begin
        counter <= '0;
        mode    <= cript_or_decript;
      end else if (ctrl[5] && counter != 3'd7) begin
        counter <= counter + 3'd1;
      end
    end
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int unsigned i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sub_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sub_inv(input logic [7:0] x);
    return gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      sbox_out <= '0;
    end else if (sbox_fwd_en) begin
      sbox_out <= {sub_fwd(sbox_in[15:8]), sub_fwd(sbox_in[7:0])};
    end else if (sbox_inv_en) begin
      sbox_out <= {sub_inv(sbox_in[15:8]), sub_inv(sbox_in[7:0])};
    end
  end

endmodule

// File: tb/tb_crypto_seq_unit.sv
// Scoreboard bench for crypto_seq_unit: strobe order, counter, reset, S-box.
module tb_crypto_seq_unit;
  localparam int unsigned R = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bgn = 1'b0;
  logic [1:0]  cript_or_decript = 2'b00;
  logic [21:0] ctrl;
  logic [2:0]  counter;
  logic [15:0] sbox_in = '0;
  logic        sbox_fwd_en = 1'b0;
  logic        sbox_inv_en = 1'b0;
  logic [15:0] sbox_out;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  int unsigned strobe_q[$];
  logic [15:0] sbox_q[$];

  logic [7:0] pt [8] = '{8'h00, 8'h01, 8'h02, 8'h0f, 8'h10, 8'h11, 8'h53, 8'hff};
  logic [7:0] st [8] = '{8'h63, 8'h7c, 8'h77, 8'h76, 8'hca, 8'h82, 8'hed, 8'h16};

  crypto_seq_unit #(.ROUNDS(R)) dut (
    .clk(clk), .rst(rst), .bgn(bgn), .cript_or_decript(cript_or_decript),
    .ctrl(ctrl), .counter(counter), .sbox_in(sbox_in),
    .sbox_fwd_en(sbox_fwd_en), .sbox_inv_en(sbox_inv_en), .sbox_out(sbox_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int unsigned nz;
    rst = 1'b0;
    tick; tick;
    total_cnt++; if (ctrl !== 22'd0) $display("FAIL rst_ctrl: got %h required 0", ctrl); else pass_cnt++;
    total_cnt++; if (counter !== 3'd0) $display("FAIL rst_counter: got %0d required 0", counter); else pass_cnt++;
    total_cnt++; if (sbox_out !== 16'h0000) $display("FAIL rst_sbox: got %h required 0000", sbox_out); else pass_cnt++;
    rst = 1'b1;
    cript_or_decript = 2'b01;
    bgn = 1'b1;
    repeat (8) tick;
    total_cnt++; if (ctrl !== (22'd1 << 7)) $display("FAIL mid_ctrl: got %h required %h", ctrl, 22'd1 << 7); else pass_cnt++;
    total_cnt++; if (counter !== 3'd1) $display("FAIL mid_counter: got %0d required 1", counter); else pass_cnt++;
    rst = 1'b0;
    sbox_fwd_en = 1'b1;
    sbox_in = 16'h0053;
    tick; tick;
    total_cnt++; if (ctrl !== 22'd0) $display("FAIL abort_ctrl: got %h required 0", ctrl); else pass_cnt++;
    total_cnt++; if (counter !== 3'd0) $display("FAIL abort_counter: got %0d required 0", counter); else pass_cnt++;
    total_cnt++; if (sbox_out !== 16'h0000) $display("FAIL abort_sbox: got %h required 0000", sbox_out); else pass_cnt++;
    rst = 1'b1;
    bgn = 1'b0;
    sbox_fwd_en = 1'b0;
    nz = 0;
    repeat (6) begin
      tick;
      if (ctrl != 22'd0) nz++;
    end
    total_cnt++; if (nz !== 0) $display("FAIL post_rst_idle: got %0d active cycles required 0", nz); else pass_cnt++;
    bgn = 1'b1;
    tick;
    total_cnt++; if (ctrl !== 22'd1) $display("FAIL post_rst_load: got %h required 000001", ctrl); else pass_cnt++;
    rst = 1'b0;
    bgn = 1'b0;
    cript_or_decript = 2'b00;
    tick;
    rst = 1'b1;
    tick;
  endtask

  task automatic test_sbox;
    logic [15:0] exp, x, y;
    int unsigned j;
    sbox_in = 16'h0053; sbox_fwd_en = 1'b1; sbox_q.push_back(16'h63ed);
    tick; sbox_fwd_en = 1'b0; exp = sbox_q.pop_front();
    total_cnt++; if (sbox_out !== exp) $display("FAIL sbox_fwd_0053: got %h required %h", sbox_out, exp); else pass_cnt++;
    sbox_in = 16'h63ed; sbox_inv_en = 1'b1; sbox_q.push_back(16'h0053);
    tick; sbox_inv_en = 1'b0; exp = sbox_q.pop_front();
    total_cnt++; if (sbox_out !== exp) $display("FAIL sbox_inv_63ed: got %h required %h", sbox_out, exp); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      j = (i + 3) % 8;
      sbox_in = {pt[i], pt[j]}; sbox_fwd_en = 1'b1; sbox_q.push_back({st[i], st[j]});
      tick; sbox_fwd_en = 1'b0; exp = sbox_q.pop_front();
      total_cnt++; if (sbox_out !== exp) $display("FAIL sbox_fwd[%0d]: got %h required %h", i, sbox_out, exp); else pass_cnt++;
      sbox_in = {st[j], st[i]}; sbox_inv_en = 1'b1; sbox_q.push_back({pt[j], pt[i]});
      tick; sbox_inv_en = 1'b0; exp = sbox_q.pop_front();
      total_cnt++; if (sbox_out !== exp) $display("FAIL sbox_inv[%0d]: got %h required %h", i, sbox_out, exp); else pass_cnt++;
    end
    sbox_in = 16'haaaa;
    tick;
    total_cnt++; if (sbox_out !== exp) $display("FAIL sbox_hold: got %h required %h", sbox_out, exp); else pass_cnt++;
    sbox_in = 16'h0001; sbox_fwd_en = 1'b1; sbox_inv_en = 1'b1; sbox_q.push_back(16'h637c);
    tick; sbox_fwd_en = 1'b0; sbox_inv_en = 1'b0; exp = sbox_q.pop_front();
    total_cnt++; if (sbox_out !== exp) $display("FAIL sbox_priority: got %h required %h", sbox_out, exp); else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      x = 16'($urandom);
      sbox_in = x; sbox_fwd_en = 1'b1;
      tick; sbox_fwd_en = 1'b0; y = sbox_out;
      sbox_in = y; sbox_inv_en = 1'b1; sbox_q.push_back(x);
      tick; sbox_inv_en = 1'b0; exp = sbox_q.pop_front();
      total_cnt++; if (sbox_out !== exp) $display("FAIL sbox_roundtrip[%0d]: got %h required %h", k, sbox_out, exp); else pass_cnt++;
    end
    sbox_in = '0;
  endtask

  task automatic test_invalid_mode;
    logic [1:0] modes [2] = '{2'b00, 2'b11};
    int unsigned nz;
    for (int m = 0; m < 2; m++) begin
      cript_or_decript = modes[m];
      bgn = 1'b1;
      nz = 0;
      repeat (10) begin
        tick;
        if (ctrl != 22'd0) nz++;
      end
      total_cnt++; if (nz !== 0) $display("FAIL invalid_mode_%b: got %0d active cycles required 0", modes[m], nz); else pass_cnt++;
      bgn = 1'b0;
      tick;
    end
    cript_or_decript = 2'b00;
  endtask

  task automatic test_op(input logic [1:0] mode, input string name);
    int unsigned exp_len, got, e;
    bit started, finished;
    strobe_q.delete();
    strobe_q.push_back(0);
    if (mode == 2'b01) begin
      strobe_q.push_back(1);
      for (int r = 0; r < int'(R); r++)
        for (int unsigned k = 2; k <= 8; k++) strobe_q.push_back(k);
      strobe_q.push_back(19); strobe_q.push_back(20); strobe_q.push_back(21);
    end else begin
      strobe_q.push_back(9);
      for (int r = 0; r < int'(R); r++) begin
        strobe_q.push_back(11); strobe_q.push_back(12); strobe_q.push_back(5);
        strobe_q.push_back(13); strobe_q.push_back(14); strobe_q.push_back(15);
        strobe_q.push_back(16); strobe_q.push_back(10);
      end
      strobe_q.push_back(17); strobe_q.push_back(18);
      strobe_q.push_back(20); strobe_q.push_back(21);
    end
    exp_len = strobe_q.size();
    cript_or_decript = mode;
    bgn = 1'b1;
    got = 0; started = 1'b0; finished = 1'b0;
    for (int c = 0; c < 60 && !finished; c++) begin
      tick;
      if (c == 2) cript_or_decript = ~mode;
      if (c == 9) bgn = 1'b0;
      if (ctrl != 22'd0) begin
        started = 1'b1;
        if (strobe_q.size() == 0) begin
          total_cnt++;
          $display("FAIL %s_extra: got %h required 000000", name, ctrl);
          finished = 1'b1;
        end else begin
          e = strobe_q.pop_front();
          got++;
          total_cnt++;
          if (ctrl !== (22'd1 << e)) $display("FAIL %s_strobe[%0d]: got %h required %h", name, got - 1, ctrl, 22'd1 << e);
          else pass_cnt++;
        end
      end else if (started) begin
        finished = 1'b1;
      end
    end
    strobe_q.delete();
    total_cnt++; if (got !== exp_len) $display("FAIL %s_len: got %0d strobes required %0d", name, got, exp_len); else pass_cnt++;
    total_cnt++; if (counter !== 3'(R)) $display("FAIL %s_counter: got %0d required %0d", name, counter, R); else pass_cnt++;
    repeat (3) tick;
    total_cnt++; if (ctrl !== 22'd0) $display("FAIL %s_idle: got %h required 000000", name, ctrl); else pass_cnt++;
    cript_or_decript = 2'b00;
  endtask

  task automatic test_retrigger;
    int unsigned loads, strobes;
    cript_or_decript = 2'b01;
    bgn = 1'b1;
    loads = 0; strobes = 0;
    repeat (40) begin
      tick;
      if (ctrl[0]) loads++;
      if (ctrl != 22'd0) strobes++;
    end
    total_cnt++; if (loads !== 1) $display("FAIL retrig_loads: got %0d required 1", loads); else pass_cnt++;
    total_cnt++; if (strobes !== 5 + 7 * R) $display("FAIL retrig_strobes: got %0d required %0d", strobes, 5 + 7 * R); else pass_cnt++;
    total_cnt++; if (ctrl !== 22'd0) $display("FAIL retrig_held: got %h required 000000", ctrl); else pass_cnt++;
    bgn = 1'b0;
    tick; tick;
    bgn = 1'b1;
    loads = 0;
    repeat (3) begin
      tick;
      if (ctrl[0]) loads++;
    end
    total_cnt++; if (loads !== 1) $display("FAIL retrig_second_load: got %0d required 1", loads); else pass_cnt++;
    bgn = 1'b0;
    repeat (25) tick;
    total_cnt++; if (ctrl !== 22'd0) $display("FAIL retrig_end: got %h required 000000", ctrl); else pass_cnt++;
    cript_or_decript = 2'b00;
  endtask

  initial begin
    test_reset();
    test_sbox();
    test_invalid_mode();
    test_op(2'b01, "encrypt");
    test_op(2'b10, "decrypt");
    test_retrigger();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
